// File: rtl/sha256_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_pkg: shared widths, constants and padder FSM states
// Rev 1.0
// ------------------------------------------------------------------
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int LEN_W   = 64;

  localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sha256_byte_mask.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_byte_mask: keeps the left-justified valid bytes of a word,
// places the 0x80 marker right after them and zeroes the rest
// Rev 1.0
// ------------------------------------------------------------------
module sha256_byte_mask
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        nbytes_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes_i) begin
        word_o[WORD_W-1-8*i -: 8] = word_i[WORD_W-1-8*i -: 8];
      end else if (3'(i) == nbytes_i) begin
        word_o[WORD_W-1-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_padder: packs a 32-bit message stream into padded 512-bit blocks
// Rev 1.0
// ------------------------------------------------------------------
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [2:0]         in_nbytes,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last,
  output logic               busy
);

  state_e            state_q;
  logic [WORD_W-1:0] blk_buf_q [16];
  logic [4:0]        wcnt_q;
  logic [LEN_W-1:0]  len_q;
  logic              first_q;
  logic              done_q;
  logic              mark_pend_q;
  logic              in_ready_q;
  logic              blk_valid_q;
  logic              blk_last_q;

  logic [4:0]        wcnt_d;
  logic [LEN_W-1:0]  len_d;
  logic [WORD_W-1:0] w_masked;
  logic              w_full_beat;

  sha256_byte_mask u_mask (
    .word_i   (in_data),
    .nbytes_i (in_nbytes),
    .word_o   (w_masked)
  );

  assign wcnt_d      = wcnt_q + 5'd1;
  assign len_d       = len_q + {58'd0, in_nbytes, 3'b000};
  assign w_full_beat = (in_nbytes == 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACC;
      wcnt_q      <= '0;
      len_q       <= '0;
      first_q     <= 1'b1;
      done_q      <= 1'b0;
      mark_pend_q <= 1'b0;
      in_ready_q  <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
      for (int i = 0; i < 16; i++) blk_buf_q[i] <= '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            blk_buf_q[wcnt_q[3:0]] <= w_masked;
            wcnt_q <= wcnt_d;
            len_q  <= len_d;
            if (in_last) begin
              done_q      <= 1'b1;
              mark_pend_q <= w_full_beat;
            end
            // A beat filling word 15 completes a block whether or not it is last
            if (wcnt_q == 5'd15) begin
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              blk_last_q  <= 1'b0;
            end else if (in_last) begin
              in_ready_q <= 1'b0;
              state_q    <= (!w_full_beat && wcnt_d == 5'd14) ? LEN : PAD;
            end
          end
        end
        PAD: begin
          blk_buf_q[wcnt_q[3:0]] <= mark_pend_q ? PAD_MARKER : '0;
          mark_pend_q <= 1'b0;
          wcnt_q      <= wcnt_d;
          if (wcnt_d == 5'd14) begin
            state_q <= LEN;
          end else if (wcnt_d == 5'd16) begin
            state_q     <= EMIT;
            blk_valid_q <= 1'b1;
            blk_last_q  <= 1'b0;
          end
        end
        LEN: begin
          wcnt_q <= wcnt_d;
          if (wcnt_q == 5'd14) begin
            blk_buf_q[14] <= len_q[63:32];
          end else begin
            blk_buf_q[15] <= len_q[31:0];
            state_q       <= EMIT;
            blk_valid_q   <= 1'b1;
            blk_last_q    <= 1'b1;
          end
        end
        EMIT: begin
          if (blk_ready) begin
            blk_valid_q <= 1'b0;
            wcnt_q      <= '0;
            first_q     <= 1'b0;
            if (blk_last_q) begin
              len_q      <= '0;
              done_q     <= 1'b0;
              first_q    <= 1'b1;
              blk_last_q <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= ACC;
            end else if (done_q) begin
              state_q <= PAD;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ACC;
            end
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign blk_data[BLOCK_W-1-WORD_W*g -: WORD_W] = blk_buf_q[g];
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_first = first_q;
  assign blk_last  = blk_last_q;
  assign busy      = (state_q != ACC) || (wcnt_q != 5'd0) || (len_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sha256_padder: directed scenarios with a queue-based block scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  sha256_padder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  blk_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stall_n  = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [513:0] act, input logic [513:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Illegal beat widths are a stimulus error, not a DUT error
  always @(posedge clk)
    if (reset_n && in_valid)
      assert (in_nbytes <= 3'd4 && (in_last || in_nbytes == 3'd4))
        else $error("illegal in_nbytes %0d", in_nbytes);

  // Reference padding built byte by byte from the message length
  task automatic push_model(input int n, input logic [7:0] seed);
    logic [7:0]  p [256];
    logic [63:0] lbits;
    int          nblk;
    blk_t        b;
    lbits = 64'(n) * 64'd8;
    nblk  = (n + 9 + 63) / 64;
    for (int j = 0; j < nblk * 64; j++) begin
      if (j < n)                  p[j] = seed + 8'(j);
      else if (j == n)            p[j] = 8'h80;
      else if (j >= nblk*64 - 8)  p[j] = lbits[63 - 8*(j - (nblk*64 - 8)) -: 8];
      else                        p[j] = 8'h00;
    end
    for (int k = 0; k < nblk; k++) begin
      for (int jj = 0; jj < 64; jj++) b.d[511 - 8*jj -: 8] = p[k*64 + jj];
      b.f = (k == 0);
      b.l = (k == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last,
                           output int t_acc);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 200 cycles");
    end
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [7:0] seed, input logic last_flag,
                          input int nbeats_lim, output int t_last);
    int          nbeats;
    logic [2:0]  nb;
    logic [31:0] w;
    if (last_flag) push_model(n, seed);
    nbeats = (n == 0) ? 1 : (n + 3) / 4;
    if (nbeats_lim < nbeats) nbeats = nbeats_lim;
    for (int b = 0; b < nbeats; b++) begin
      nb = (last_flag && b == nbeats - 1) ? 3'(n - 4*b) : 3'd4;
      for (int k = 0; k < 4; k++)
        w[31 - 8*k -: 8] = (3'(k) < nb) ? seed + 8'(4*b + k) : 8'hEE;
      send_beat(w, nb, last_flag && (b == nbeats - 1), t_last);
    end
  endtask

  task automatic check_latency(input int t0, input int lat, input string name);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!blk_valid && i < 100);
    chk(name, 514'(cyc - t0), 514'(lat));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || blk_valid) && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    chk(name, 514'(exp_q.size()), 514'd0);
  endtask

  // Downstream ready: stall each new block for stall_n cycles
  initial begin
    blk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (blk_valid && stall_cnt < stall_n) begin
        blk_ready = 1'b0;
        stall_cnt++;
      end else begin
        blk_ready = 1'b1;
        if (!blk_valid) stall_cnt = 0;
      end
    end
  end

  // Monitor: handshakes pop the scoreboard, stalls must hold the block
  initial begin
    blk_t e;
    logic [513:0] held;
    logic         stalled_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && blk_valid) begin
        chk("in_ready_during_block", 514'(in_ready), 514'd0);
        if (stalled_prev) chk("stall_stable", {blk_data, blk_first, blk_last}, held);
        if (!blk_ready) begin
          stalled_prev = 1'b1;
          held = {blk_data, blk_first, blk_last};
        end else begin
          stalled_prev = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_block: got %0h, expected no block", blk_data);
          end else begin
            e = exp_q.pop_front();
            chk("blk_data",  514'(blk_data),  514'(e.d));
            chk("blk_first", 514'(blk_first), 514'(e.f));
            chk("blk_last",  514'(blk_last),  514'(e.l));
          end
        end
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  514'(in_ready),  514'd1);
    chk({tag, "_blk_valid"}, 514'(blk_valid), 514'd0);
    chk({tag, "_blk_data"},  514'(blk_data),  514'd0);
    chk({tag, "_blk_first"}, 514'(blk_first), 514'd1);
    chk({tag, "_blk_last"},  514'(blk_last),  514'd0);
    chk({tag, "_busy"},      514'(busy),      514'd0);
  endtask

  initial begin
    int   t;
    blk_t b;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // "abc" with a garbage fourth byte that must be masked off
    b.d = {32'h6162_6380, 448'd0, 32'h0000_0018}; b.f = 1'b1; b.l = 1'b1;
    exp_q.push_back(b);
    send_beat(32'h6162_63EE, 3'd3, 1'b1, t);
    check_latency(t, 16, "abc_latency");
    drain("abc_drain");
    chk("idle_busy", 514'(busy), 514'd0);

    // Empty message
    b.d = {32'h8000_0000, 480'd0}; b.f = 1'b1; b.l = 1'b1;
    exp_q.push_back(b);
    send_beat(32'hDEAD_BEEF, 3'd0, 1'b1, t);
    drain("empty_drain");

    send_msg(55, 8'h10, 1'b1, 100, t);
    drain("len55_drain");
    send_msg(56, 8'h40, 1'b1, 100, t);
    drain("len56_drain");

    stall_n = 5;
    send_msg(64, 8'hA0, 1'b1, 100, t);
    check_latency(t, 1, "full_block_latency");
    drain("len64_drain");
    stall_n = 0;

    // Partial message abandoned by reset, then "abc" again
    send_msg(40, 8'h33, 1'b0, 7, t);
    chk("partial_busy", 514'(busy), 514'd1);
    reset_n = 1'b0;
    #2;
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    b.d = {32'h6162_6380, 448'd0, 32'h0000_0018}; b.f = 1'b1; b.l = 1'b1;
    exp_q.push_back(b);
    send_beat(32'h6162_6300, 3'd3, 1'b1, t);
    check_latency(t, 16, "abc2_latency");
    drain("abc2_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
